if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction-fetch stage of the pipelined RISC-V core, sitting directly upstream of the datapath's decode stage. It owns the fetch PC, issues word-aligned requests to a fixed one-cycle-latency instruction memory, and buffers returned instructions in a small FIFO together with their PC and PC+4. On a taken branch or jump it accepts a redirect from the datapath, and on a hazard it accepts a stall. It presents one instruction per cycle to decode.

## Interface
Parameters:
- DATA_W, 32, instruction and address width.
- DEPTH, 4, instruction queue entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  single core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request this cycle. Memory always accepts a request.
- imem_addr  out  DATA_W  fetch address; bits [1:0] are always 0.
- imem_rdata  in  DATA_W  instruction for the request issued in the previous cycle.
- redirect_valid  in  1  taken branch or jump from the datapath.
- redirect_pc  in  DATA_W  redirect target; bits [1:0] are ignored and treated as 0.
- stall  in  1  decode cannot accept the head instruction this cycle.
- if_valid  out  1  the head queue entry is presented.
- if_instr  out  DATA_W  head instruction; 32'h0000_0013 (NOP) when if_valid=0.
- if_pc  out  DATA_W  PC of the head instruction; 0 when if_valid=0.
- if_pc_plus4  out  DATA_W  if_pc+4, modulo 2^DATA_W; 0 when if_valid=0.

## Operation
Internal state:
- fetch_pc register.
- req_q flag: a request was issued last cycle.
- Circular queue of DEPTH {instr, pc} entries, with head pointer, tail pointer and count.

Request issue:
- imem_req = !reset && !redirect_valid && (count + req_q < DEPTH).
- The check is conservative: it ignores a same-cycle pop.
- imem_addr = fetch_pc.
- When imem_req=1, fetch_pc ← fetch_pc+4, wrapping 32'hFFFF_FFFC → 0.

Response:
- When req_q=1 and redirect_valid=0, {imem_rdata, pc of that request} is enqueued at the tail.
- A pc_q register holds the PC of the outstanding request.

Pop:
- Occurs when if_valid && !stall && !redirect_valid.
- if_* outputs are driven from the head entry. if_valid = (count != 0).

Redirect (highest priority):
- Queue cleared: count, head and tail all ← 0.
- Any response arriving in the same cycle is dropped.
- No request is issued that cycle.
- fetch_pc ← {redirect_pc[31:2], 2'b00}.
- stall is ignored that cycle.

Simultaneous enqueue and pop: count is unchanged and both pointers advance.

The queue can never overflow, by construction of the issue rule. Bench asserts that no enqueue occurs at count=DEPTH.

Reset (also valid mid-operation):
- fetch_pc ← RESET_PC, queue cleared, req_q ← 0.
- A response due in the cycle after reset is discarded.
- Output reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=32'h13, if_pc=0, if_pc_plus4=0.

## Timing
- Fetch latency: a request in cycle n is presented on if_* in cycle n+2 (enqueue at the end of n+1).
- After reset is released in cycle 0: request RESET_PC in cycle 0, if_valid=1 in cycle 2.
- After a redirect in cycle t:
  - if_valid=0 in cycles t+1 and t+2.
  - Target request issued in t+1; target presented in t+3.
  - This is a 2-bubble redirect penalty.
- Steady state with stall=0: one instruction per cycle, no bubbles.
- Leaving a full-queue stall: no bubble.
- Outputs are combinational only from registers. There is no input-to-output combinational path, except imem_req depending on redirect_valid.

## Configuration
- FETCH_PERF_EN, when defined, adds two output ports:
  - perf_fetched  out  32: counts enqueued instructions.
  - perf_flushes  out  32: counts cycles with redirect_valid=1.
- Both counters reset to 0 and wrap at 2^32.
- When FETCH_PERF_EN is undefined, these ports and their logic are absent and all other behaviour is identical.

## Test plan
- Reset release, RESET_PC=0, memory returns instr=addr: if_valid first high in cycle 2 with pc 0, then pcs 4, 8, 12 on consecutive cycles; if_pc_plus4=if_pc+4.
- stall=1 for 8 cycles from the first valid:
  - Queue fills to 4 and imem_req falls to 0.
  - if_pc holds at 0.
  - After release, pcs 0, 4, 8, 12, 16, 20 appear with no gap.
- Queue holding 3 entries, redirect_valid=1 with redirect_pc=0x100 in cycle t: if_valid=0 in t+1 and t+2, pc 0x100 in t+3, and no pre-redirect PC ever appears.
- Redirect with stall=1 in the same cycle to 0x103: fetch proceeds at 0x100. Redirect to 0xFFFF_FFF8: pcs FFFFFFF8, FFFFFFFC, 00000000 in order.
- reset asserted for 1 cycle mid-stream while a request is outstanding: all outputs at reset values, and the first post-reset instruction is pc RESET_PC two cycles after release.
- With FETCH_PERF_EN: 10 instructions fetched and 2 redirects give perf_fetched ≥ 10 and perf_flushes = 2.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue -- instruction-fetch stage with a small instruction queue.
//
// Owns the fetch PC and issues word-aligned requests to an instruction memory
// with a fixed one-cycle latency. Each returned instruction is queued with its
// PC. The head entry is presented to decode together with PC+4.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   imem_req, imem_addr   fetch request and word-aligned address
//   imem_rdata            instruction for the previous cycle's request
//   redirect_valid/_pc    taken branch/jump from the datapath (highest priority)
//   stall                 decode cannot take the head instruction this cycle
//   if_valid/_instr/_pc/_pc_plus4
//                         head entry (NOP/0/0 when if_valid=0)
//
// Optional build macro FETCH_PERF_EN adds perf_fetched and perf_flushes.
//
// Handshake: an instruction transfers to decode in any cycle where
// if_valid=1 and stall=0, unless redirect_valid=1. A redirect flushes the
// queue, and stall is ignored in that cycle. All if_* outputs come from
// registers only.
module if_fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  logic [DATA_W-1:0] fetch_pc;
  logic [DATA_W-1:0] pc_q;     // PC of the request outstanding in memory
  logic              req_q;    // a request was issued last cycle

  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [DATA_W-1:0] q_pc    [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              enq;
  logic              pop;
  logic [OCC_W-1:0]  occupancy;

  // Reserve a slot for the in-flight response so the queue cannot overflow.
  // A same-cycle pop is deliberately not credited.
  assign occupancy = OCC_W'(count) + OCC_W'(req_q);
  assign imem_req  = !reset && !redirect_valid && (occupancy < OCC_W'(DEPTH));
  assign imem_addr = fetch_pc;

  // A response arriving during a redirect or reset belongs to a dead path.
  assign enq = req_q && !redirect_valid && !reset;
  assign pop = if_valid && !stall && !redirect_valid;

  assign if_valid    = (count != '0);
  assign if_instr    = if_valid ? q_instr[head] : NOP;
  assign if_pc       = if_valid ? q_pc[head] : '0;
  assign if_pc_plus4 = if_valid ? (q_pc[head] + DATA_W'(4)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[DATA_W-1:2], 2'b00};
      req_q    <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      req_q <= imem_req;
      if (imem_req) begin
        pc_q     <= fetch_pc;
        fetch_pc <= fetch_pc + DATA_W'(4);   // wraps modulo 2^DATA_W
      end
      if (enq) tail <= tail + PTR_W'(1);     // DEPTH is a power of two
      if (pop) head <= head + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; entries are qualified by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (enq)            perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue -- directed bench for if_fetch_queue.
// The memory model returns instr = addr ^ MEM_XOR one cycle after the address.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] MEM_XOR = 32'hCAFE_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  if_fetch_queue #(.DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  always @(posedge clk) imem_rdata <= imem_addr ^ MEM_XOR;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_instr"}, if_instr, pc ^ MEM_XOR);
    check({tag, "_plus4"}, if_pc_plus4, pc + 32'd4);
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
    check({tag, "_instr"}, if_instr, 32'h0000_0013);
    check({tag, "_pc"}, if_pc, 32'd0);
    check({tag, "_plus4"}, if_pc_plus4, 32'd0);
  endtask

  // No enqueue may ever land on a full queue.
  always @(negedge clk) begin
    check("no_overflow", {31'b0, (dut.enq && (dut.count == DEPTH))}, 32'd0);
  end

  // ---------------- driver ----------------
  // One clock cycle: inputs applied just after the edge, outputs settled 1ns later.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic st);
    @(posedge clk);
    #1;
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;

    // ---- reset state and first fetch ----
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    expect_empty("rst");
    cyc(0, 0, 0, 0);                       // cycle 0
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'd0);
    expect_empty("c0");
    cyc(0, 0, 0, 0);                       // cycle 1
    check("c1_addr", imem_addr, 32'd4);
    expect_empty("c1");
    for (int i = 0; i < 4; i++) begin      // cycles 2..5
      cyc(0, 0, 0, 0);
      expect_head("stream", 32'(i * 4));
    end

    // ---- stall until full, then drain without bubbles ----
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);                       // cycle 0
    cyc(0, 0, 0, 0);                       // cycle 1
    for (int c = 2; c <= 9; c++) begin
      cyc(0, 0, 0, 1);
      expect_head("stall_hold", 32'd0);
      check("stall_req", {31'b0, imem_req}, (c >= 4) ? 32'd0 : 32'd1);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    while (exp_q.size() != 0) begin        // cycles 10..15
      cyc(0, 0, 0, 0);
      expect_head("drain", exp_q.pop_front());
    end

    // ---- redirect with 3 entries queued ----
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h100, 0);                 // t: 3 entries held
    check("rd_req_block", {31'b0, imem_req}, 32'd0);
    expect_head("rd_t", 32'd0);
    cyc(0, 0, 0, 0);                       // t+1
    check("rd_t1_req", {31'b0, imem_req}, 32'd1);
    check("rd_t1_addr", imem_addr, 32'h100);
    expect_empty("rd_t1");
    cyc(0, 0, 0, 0);                       // t+2
    check("rd_t2_addr", imem_addr, 32'h104);
    expect_empty("rd_t2");
    for (int i = 0; i < 3; i++) begin      // t+3..t+5
      cyc(0, 0, 0, 0);
      expect_head("rd_tgt", 32'h100 + 32'(i * 4));
    end

    // ---- redirect with stall, unaligned target ----
    cyc(0, 1, 32'h103, 1);
    cyc(0, 0, 0, 0);
    check("ua_addr", imem_addr, 32'h100);
    expect_empty("ua_t1");
    cyc(0, 0, 0, 0);
    expect_empty("ua_t2");
    cyc(0, 0, 0, 0);
    expect_head("ua_t3", 32'h100);
    cyc(0, 0, 0, 0);
    expect_head("ua_t4", 32'h104);

    // ---- redirect near the top of the address space ----
    cyc(0, 1, 32'hFFFF_FFF8, 0);
    cyc(0, 0, 0, 0);
    check("wrap_addr1", imem_addr, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    check("wrap_addr2", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    expect_head("wrap_a", 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    expect_head("wrap_b", 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    expect_head("wrap_c", 32'h0000_0000);
    cyc(0, 0, 0, 0);
    expect_head("wrap_d", 32'h0000_0004);
`ifdef FETCH_PERF_EN
    check("perf_flushes", perf_flushes, 32'd3);
    check("perf_fetched_ge10", {31'b0, (perf_fetched >= 32'd10)}, 32'd1);
`endif

    // ---- reset mid-stream with a request outstanding ----
    cyc(1, 0, 0, 0);
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rel_req", {31'b0, imem_req}, 32'd1);
    expect_empty("mid_rst");
`ifdef FETCH_PERF_EN
    check("perf_rst_fetched", perf_fetched, 32'd0);
    check("perf_rst_flushes", perf_flushes, 32'd0);
`endif
    cyc(0, 0, 0, 0);
    expect_empty("mid_c1");
    cyc(0, 0, 0, 0);
    expect_head("mid_c2", 32'd0);
    cyc(0, 0, 0, 0);
    expect_head("mid_c3", 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
